// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   MIPS instruction-fetch stage with the IF/ID pipeline register.
//   Owns the PC, presents it to the instruction memory (combinational read,
//   same-cycle data) and latches the fetched word together with PC+4 into
//   IF/ID for decode. Handles load-use stall, EX branch redirect, ID jump
//   redirect and explicit flush.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high
//   imem_address     instruction memory address (always equals pc)
//   imem_instruction instruction memory read data
//   stall            hold pc, IF/ID and fetch_count
//   flush            insert a bubble into IF/ID
//   branch_taken     EX-stage branch resolved taken
//   branch_target    branch destination
//   jump             ID-stage j/jal decoded
//   jump_target      jump destination
//   pc               current fetch PC
//   if_id_instr      registered instruction for decode
//   if_id_pc_plus4   registered PC+4 of that instruction
//   if_id_valid      1 = if_id_instr is a real fetched instruction
//   fetch_count      number of valid instructions latched into IF/ID
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      imem_address,
    input  logic [31:0]      imem_instruction,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc_plus4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count
);

    logic [31:0] pc_plus4;

    // Redirect targets are forced to a word boundary before reaching the PC.
    function automatic logic [31:0] word_align(input logic [31:0] target);
        return target & 32'hFFFF_FFFC;
    endfunction

    // Fetch: zero-latency memory, so the word for pc is available this cycle.
    assign imem_address = pc;
    assign pc_plus4     = pc + 32'd4;   // wraps silently at 2^32

    // IF/ID boundary: PC update and pipeline register, priority
    // branch > jump > stall > flush > normal fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            fetch_count    <= '0;
        end else if (branch_taken) begin
            pc             <= word_align(branch_target);
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (jump) begin
            pc             <= word_align(jump_target);
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (stall) begin
            // pc and fetch_count hold; a concurrent flush still kills IF/ID.
            if (flush) begin
                if_id_instr    <= NOP_INSTR;
                if_id_pc_plus4 <= 32'd0;
                if_id_valid    <= 1'b0;
            end
        end else if (flush) begin
            pc             <= pc_plus4;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else begin
            pc             <= pc_plus4;
            if_id_instr    <= imem_instruction;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            fetch_count    <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        stall, flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, if_id_instr, if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    always #5 clk = ~clk;

    if_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump             (jump),
        .jump_target      (jump_target),
        .pc               (pc),
        .if_id_instr      (if_id_instr),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_valid      (if_id_valid),
        .fetch_count      (fetch_count)
    );

    // instruction memory contents: a distinct word per address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_instruction = mem_word(imem_address);

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    // behaviour of one rising edge, from the stage's rules
    task automatic model_edge();
        if (branch_taken) begin
            m_pc = {branch_target[31:2], 2'b00};
            model_bubble();
        end else if (jump) begin
            m_pc = {jump_target[31:2], 2'b00};
            model_bubble();
        end else if (stall) begin
            if (flush) model_bubble();
        end else if (flush) begin
            m_pc = m_pc + 32'd4;
            model_bubble();
        end else begin
            m_instr = mem_word(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic idle();
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // power-on reset
        reset = 1'b1;
        idle();
        #1;
        n_cmp++;
        if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL por_state: pc=%h instr=%h pc4=%h valid=%b cnt=%0d, need all zero",
                     pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        // run a few fetches, then stall and assert reset between edges
        repeat (3) tick();
        stall = 1'b1;
        tick();
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 32'h0 || imem_address !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_pc: pc=%h addr=%h, need 0", pc, imem_address);
        end
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_ifid: valid=%b instr=%h pc4=%h, need 0/0/0",
                     if_id_valid, if_id_instr, if_id_pc_plus4);
        end
        n_cmp++;
        if (fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_count: got %0d, need 0", fetch_count);
        end
        idle();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_w [3];
        do_reset();
        idle();
        for (int i = 0; i < 3; i++) exp_w[i] = mem_word(32'(i * 4));
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (if_id_instr !== exp_w[i] || if_id_pc_plus4 !== 32'(i * 4 + 4) || if_id_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_fetch%0d: instr=%h pc4=%h valid=%b, need %h %h 1",
                         i, if_id_instr, if_id_pc_plus4, if_id_valid, exp_w[i], 32'(i * 4 + 4));
            end
        end
        n_cmp++;
        if (pc !== 32'd12 || imem_address !== 32'd12 || fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL seq_end: pc=%h addr=%h cnt=%0d, need 0000000c 0000000c 3",
                     pc, imem_address, fetch_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        idle();
        repeat (2) tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (pc !== 32'd8 || if_id_instr !== mem_word(32'd4) || if_id_pc_plus4 !== 32'd8 ||
                if_id_valid !== 1'b1 || fetch_count !== 32'd2) begin
                n_fail++;
                $display("FAIL stall_hold%0d: pc=%h instr=%h pc4=%h valid=%b cnt=%0d, need 8 %h 8 1 2",
                         i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count, mem_word(32'd4));
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (if_id_instr !== mem_word(32'd8) || if_id_pc_plus4 !== 32'd12 || fetch_count !== 32'd3 || pc !== 32'd12) begin
            n_fail++;
            $display("FAIL stall_release: instr=%h pc4=%h cnt=%0d pc=%h, need %h 0000000c 3 0000000c",
                     if_id_instr, if_id_pc_plus4, fetch_count, pc, mem_word(32'd8));
        end
    endtask

    task automatic test_branch();
        do_reset();
        idle();
        repeat (2) tick();
        branch_taken = 1'b1; branch_target = 32'h40;
        jump = 1'b1; jump_target = 32'h80;
        stall = 1'b1; flush = 1'b1;
        tick();
        n_cmp++;
        if (pc !== 32'h40 || imem_address !== 32'h40 || if_id_valid !== 1'b0 ||
            if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0 || fetch_count !== 32'd2) begin
            n_fail++;
            $display("FAIL branch_redirect: pc=%h addr=%h valid=%b instr=%h pc4=%h cnt=%0d, need 40 40 0 0 0 2",
                     pc, imem_address, if_id_valid, if_id_instr, if_id_pc_plus4, fetch_count);
        end
        idle();
        tick();
        n_cmp++;
        if (if_id_instr !== mem_word(32'h40) || if_id_pc_plus4 !== 32'h44 || if_id_valid !== 1'b1 || fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL branch_target_fetch: instr=%h pc4=%h valid=%b cnt=%0d, need %h 44 1 3",
                     if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count, mem_word(32'h40));
        end
    endtask

    task automatic test_jump_flush();
        do_reset();
        idle();
        tick();
        jump = 1'b1; jump_target = 32'h23; stall = 1'b1; flush = 1'b1;
        tick();
        n_cmp++;
        if (pc !== 32'h20 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || fetch_count !== 32'd1) begin
            n_fail++;
            $display("FAIL jump_redirect: pc=%h valid=%b instr=%h cnt=%0d, need 20 0 0 1",
                     pc, if_id_valid, if_id_instr, fetch_count);
        end
        idle();
        tick();
        flush = 1'b1;
        tick();
        n_cmp++;
        if (pc !== 32'h28 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
            if_id_pc_plus4 !== 32'h0 || fetch_count !== 32'd2) begin
            n_fail++;
            $display("FAIL flush_only: pc=%h valid=%b instr=%h pc4=%h cnt=%0d, need 28 0 0 0 2",
                     pc, if_id_valid, if_id_instr, if_id_pc_plus4, fetch_count);
        end
        idle();
        tick();
        stall = 1'b1; flush = 1'b1;
        tick();
        n_cmp++;
        if (pc !== 32'h2C || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_flush: pc=%h valid=%b instr=%h cnt=%0d, need 2c 0 0 3",
                     pc, if_id_valid, if_id_instr, fetch_count);
        end
        idle();
    endtask

    task automatic test_wrap();
        do_reset();
        idle();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        tick();
        idle();
        tick();
        n_cmp++;
        if (if_id_pc_plus4 !== 32'h0 || pc !== 32'h0 || if_id_instr !== mem_word(32'hFFFF_FFFC) || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pc_wrap: pc4=%h pc=%h instr=%h valid=%b, need 0 0 %h 1",
                     if_id_pc_plus4, pc, if_id_instr, if_id_valid, mem_word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_random();
        do_reset();
        idle();
        for (int i = 0; i < 400; i++) begin
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump          = ($urandom_range(0, 9) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 5) == 0);
            branch_target = $urandom;
            jump_target   = $urandom;
            tick();
            n_cmp++;
            if ({pc, imem_address, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count} !==
                {m_pc, m_pc, m_instr, m_pc4, m_valid, m_cnt}) begin
                n_fail++;
                $display("FAIL random_cycle%0d: pc=%h instr=%h pc4=%h valid=%b cnt=%0d, need %h %h %h %b %0d",
                         i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count,
                         m_pc, m_instr, m_pc4, m_valid, m_cnt);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_flush();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
